wb_decode_mux: RTL and testbench

Parametrised Wishbone classic single-master to N-slave decoder and mux for the digital top. It supersedes the fixed 8-port interconnect. It folds the Caravel address-window filter into the block and adds three things:
- an error response for unmapped addresses inside the window;
- a per-transaction timeout watchdog;
- sticky error status with a captured fault address.

---
 rtl/wb_decode_mux.sv | 175 +++++++++++++++++
 tb/tb_wb_decode_mux.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_decode_mux.sv
// wb_decode_mux
// Wishbone classic single-master to N-slave decoder and response mux.
// Requests outside the master address window are ignored. In-window requests
// that match no slave get a one-cycle error response. A watchdog ends a slave
// transaction that never answers. Both fault kinds are recorded in sticky
// status bits, together with the address that caused the fault.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o            master side (cyc/stb/we/adr/dat/sel in; dat/ack/err/rty out)
//   wbs_*_o / wbs_*_i            per-slave side, flattened, with slave k at slice k
//   err_status_o                 sticky {timeout, decode_miss}
//   err_adr_o                    address of the most recent fault
//   err_clr_i                    one-cycle pulse that clears status and fault address
module wb_decode_mux #(
  parameter int NUM_SLAVES     = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK = 32'hff00_0000,
  parameter logic [ADDR_WIDTH-1:0] WIN_ADDR = 32'h3000_0000,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_ni,
  input  logic                             wbm_cyc_i,
  input  logic                             wbm_stb_i,
  input  logic                             wbm_we_i,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  input  logic [SEL_WIDTH-1:0]             wbm_sel_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic                             wbm_rty_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  output logic [NUM_SLAVES-1:0]            wbs_we_o,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
  output logic [NUM_SLAVES*SEL_WIDTH-1:0]  wbs_sel_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_rty_i,
  output logic [1:0]                       err_status_o,
  output logic [ADDR_WIDTH-1:0]            err_adr_o,
  input  logic                             err_clr_i
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_ERR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic             req;
  logic             in_win;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             active;
  logic             sel_ack;
  logic             sel_err;
  logic             sel_rty;

  assign req    = wbm_cyc_i & wbm_stb_i;
  assign in_win = (wbm_adr_i & WIN_MASK) == WIN_ADDR;
  assign active = (state == S_ACTIVE);

  // Scan from the top down so the lowest matching slave is the last
  // assignment and therefore wins when address ranges overlap.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((wbm_adr_i & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  assign sel_ack = wbs_ack_i[idx];
  assign sel_err = wbs_err_i[idx];
  assign sel_rty = wbs_rty_i[idx];

  // Saturate rather than wrap so a disabled watchdog can never fire.
  assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

  // Only the latched slave sees the master handshake; the payload is broadcast.
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    if (active) begin
      wbs_cyc_o[idx] = wbm_cyc_i;
      wbs_stb_o[idx] = wbm_stb_i;
    end
  end

  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};

  // Responses come straight from the latched slave while ACTIVE; in IDLE and
  // ERR they are forced low, so late responses after abort or timeout vanish.
  assign wbm_ack_o = active & sel_ack;
  assign wbm_rty_o = active & sel_rty;
  assign wbm_err_o = (state == S_ERR) | (active & sel_err);
  assign wbm_dat_o = active ? wbs_dat_i[idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  // NOTE: sequential state uses non-blocking assignments only. A later
  // assignment to the same bit in this block overrides an earlier one, which
  // is how a fault set beats a same-cycle clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      err_status_o <= 2'b00;
      err_adr_o    <= '0;
    end else begin
      if (err_clr_i) begin
        err_status_o <= 2'b00;
        err_adr_o    <= '0;
      end

      case (state)
        S_IDLE: begin
          if (req && in_win) begin
            if (hit_any) begin
              state <= S_ACTIVE;
              idx   <= hit_idx;
              cnt   <= '0;
            end else begin
              state           <= S_ERR;
              err_status_o[0] <= 1'b1;
              err_adr_o       <= wbm_adr_i;
            end
          end
        end

        S_ACTIVE: begin
          if (sel_ack || sel_err || sel_rty) begin
            state <= S_IDLE;
          end else if (!wbm_cyc_i) begin
            state <= S_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_next == CNT_W'(TIMEOUT_CYCLES))) begin
            state           <= S_ERR;
            err_status_o[1] <= 1'b1;
            err_adr_o       <= wbm_adr_i;
          end else begin
            cnt <= cnt_next;
          end
        end

        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_decode_mux.sv
// Directed testbench for wb_decode_mux: 8 slaves, watchdog of 4 cycles.
// Inputs change 2 time units after the rising edge; outputs are sampled
// 1 time unit later, well away from the next edge.
module tb_wb_decode_mux;

  localparam int NS = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // Slave 7 overlaps slaves 2 and 5; the lower index must win there.
  localparam logic [NS*AW-1:0] S_ADDR = {
    32'h3080_0000, 32'h3006_0000, 32'h3082_0000, 32'h3004_0000,
    32'h3003_0000, 32'h3081_0000, 32'h3001_0000, 32'h3000_0000};
  localparam logic [NS*AW-1:0] S_MASK = {
    32'hfff0_0000, 32'hffff_0000, 32'hffff_0000, 32'hffff_0000,
    32'hffff_0000, 32'hffff_0000, 32'hffff_0000, 32'hffff_0000};

  logic clk = 1'b0;
  logic rst_n;
  logic m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdat;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_rdat;
  logic m_ack, m_err, m_rty;
  logic [NS-1:0] s_cyc, s_stb, s_we;
  logic [NS*AW-1:0] s_adr;
  logic [NS*DW-1:0] s_wdat;
  logic [NS*SW-1:0] s_sel;
  logic [NS*DW-1:0] s_rdat;
  logic [NS-1:0] s_ack, s_err, s_rty;
  logic [1:0] err_status;
  logic [AW-1:0] err_adr;
  logic err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_decode_mux #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .WIN_MASK(32'hff00_0000), .WIN_ADDR(32'h3000_0000),
    .SLAVE_ADDR(S_ADDR), .SLAVE_MASK(S_MASK), .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_wdat), .wbm_sel_i(m_sel),
    .wbm_dat_o(m_rdat), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_sel_o(s_sel),
    .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .err_status_o(err_status), .err_adr_o(err_adr), .err_clr_i(err_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic master_idle();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = '0; m_wdat = '0; m_sel = '0;
  endtask

  task automatic master_req(input logic [AW-1:0] adr, input logic we);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
    m_adr = adr; m_sel = '1;
  endtask

  task automatic slaves_quiet();
    s_ack = '0; s_err = '0; s_rty = '0; s_rdat = '0;
  endtask

  initial begin
    master_idle();
    slaves_quiet();
    err_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_stb", 64'(s_stb), 64'h0);
    check("rst_cyc", 64'(s_cyc), 64'h0);
    check("rst_resp", 64'({m_ack, m_err, m_rty}), 64'h0);
    check("rst_rdat", 64'(m_rdat), 64'h0);
    check("rst_status", 64'(err_status), 64'h0);
    check("rst_err_adr", 64'(err_adr), 64'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Zero-wait write to slave 5.
    tick();
    master_req(32'h3082_0004, 1'b1);
    m_wdat = 32'h1234_5678;
    #1;
    check("wr_decode_cycle_stb", 64'(s_stb), 64'h0);
    check("wr_decode_cycle_ack", 64'(m_ack), 64'h0);
    tick();
    check("wr_s5_stb", 64'(s_stb), 64'h20);
    check("wr_s5_cyc", 64'(s_cyc), 64'h20);
    check("wr_s5_adr", 64'(s_adr[5*AW +: AW]), 64'h3082_0004);
    check("wr_s5_dat", 64'(s_wdat[5*DW +: DW]), 64'h1234_5678);
    check("wr_s5_we", 64'(s_we[5]), 64'h1);
    s_ack[5] = 1'b1;
    #1;
    check("wr_ack", 64'(m_ack), 64'h1);
    tick();
    master_idle(); slaves_quiet();
    #1;
    check("wr_after_stb", 64'(s_stb), 64'h0);
    check("wr_after_ack", 64'(m_ack), 64'h0);

    // Read from slave 2 with three wait states.
    tick();
    master_req(32'h3081_0100, 1'b0);
    tick();
    #1;
    check("rd_s2_stb", 64'(s_stb), 64'h04);
    check("rd_wait1_ack", 64'(m_ack), 64'h0);
    tick();
    tick();
    #1;
    check("rd_wait3_ack", 64'(m_ack), 64'h0);
    tick();
    s_rdat[2*DW +: DW] = 32'hDEAD_BEEF;
    s_ack[2] = 1'b1;
    #1;
    check("rd_ack", 64'(m_ack), 64'h1);
    check("rd_data", 64'(m_rdat), 64'hDEAD_BEEF);
    check("rd_no_err", 64'(m_err), 64'h0);
    tick();
    master_idle(); slaves_quiet();
    #1;
    check("rd_idle_data", 64'(m_rdat), 64'h0);
    check("rd_status", 64'(err_status), 64'h0);

    // Overlap: slave 5 beats slave 7, then back-to-back to slave 7 only.
    tick();
    master_req(32'h3082_1000, 1'b0);
    tick();
    check("ovl_s5_wins", 64'(s_stb), 64'h20);
    s_ack[5] = 1'b1;
    #1;
    check("ovl_ack", 64'(m_ack), 64'h1);
    tick();
    s_ack[5] = 1'b0;
    m_adr = 32'h3085_0000;
    #1;
    check("b2b_decode_stb", 64'(s_stb), 64'h0);
    tick();
    check("b2b_s7_stb", 64'(s_stb), 64'h80);
    s_ack[7] = 1'b1;
    #1;
    check("b2b_ack", 64'(m_ack), 64'h1);
    tick();
    master_idle(); slaves_quiet();

    // Slave retry passes through.
    tick();
    master_req(32'h3001_0000, 1'b0);
    tick();
    s_rty[1] = 1'b1;
    #1;
    check("rty_pass", 64'({m_ack, m_err, m_rty}), 64'h1);
    tick();
    master_idle(); slaves_quiet();

    // Unmapped in-window address.
    tick();
    master_req(32'h30FF_0000, 1'b0);
    #1;
    check("miss_cycle1_err", 64'(m_err), 64'h0);
    tick();
    #1;
    check("miss_err", 64'(m_err), 64'h1);
    check("miss_no_stb", 64'(s_stb), 64'h0);
    check("miss_no_ack", 64'(m_ack), 64'h0);
    check("miss_status", 64'(err_status), 64'h1);
    check("miss_err_adr", 64'(err_adr), 64'h30FF_0000);
    tick();
    master_idle();
    #1;
    check("miss_err_one_cycle", 64'(m_err), 64'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("miss_clr_status", 64'(err_status), 64'h0);
    check("miss_clr_adr", 64'(err_adr), 64'h0);

    // Out-of-window request is ignored for 20 cycles.
    tick();
    master_req(32'h2000_0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      check("oow_quiet", 64'({s_cyc, s_stb, m_ack, m_err, m_rty}), 64'h0);
    end
    check("oow_status", 64'(err_status), 64'h0);
    master_idle();

    // Master abort; a late slave ack is ignored.
    tick();
    master_req(32'h3001_0004, 1'b0);
    tick();
    check("abort_s1_stb", 64'(s_stb), 64'h02);
    tick();
    master_idle();
    #1;
    check("abort_cyc_drop", 64'(s_cyc), 64'h0);
    tick();
    s_ack[1] = 1'b1;
    #1;
    check("abort_late_ack", 64'(m_ack), 64'h0);
    tick();
    slaves_quiet();

    // Watchdog: slave 0 never answers.
    tick();
    master_req(32'h3000_0010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("to_stb_high", 64'(s_stb), 64'h01);
      check("to_no_err", 64'(m_err), 64'h0);
    end
    tick();
    s_ack[0] = 1'b1;
    #1;
    check("to_stb_dropped", 64'(s_stb), 64'h0);
    check("to_err", 64'(m_err), 64'h1);
    check("to_late_ack", 64'(m_ack), 64'h0);
    check("to_status", 64'(err_status), 64'h2);
    check("to_err_adr", 64'(err_adr), 64'h3000_0010);
    tick();
    master_idle(); slaves_quiet();
    #1;
    check("to_err_one_cycle", 64'(m_err), 64'h0);

    // Miss and clear in the same cycle: the new miss survives the clear.
    tick();
    master_req(32'h30FF_0000, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("setclr_status", 64'(err_status), 64'h1);
    check("setclr_adr", 64'(err_adr), 64'h30FF_0000);
    tick();
    master_idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("clr_status", 64'(err_status), 64'h0);

    // Reset during an ACTIVE wait, then a normal access.
    tick();
    master_req(32'h3081_0000, 1'b0);
    tick();
    check("rst_mid_stb_before", 64'(s_stb), 64'h04);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_stb", 64'(s_stb), 64'h0);
    check("rst_mid_resp", 64'({s_cyc, m_ack, m_err, m_rty}), 64'h0);
    master_idle();
    tick();
    rst_n = 1'b1;
    tick();
    master_req(32'h3006_0000, 1'b1);
    tick();
    check("post_rst_s6_stb", 64'(s_stb), 64'h40);
    s_ack[6] = 1'b1;
    #1;
    check("post_rst_ack", 64'(m_ack), 64'h1);
    tick();
    master_idle(); slaves_quiet();
    #1;
    check("post_rst_idle", 64'({s_stb, m_ack}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
